// File: rtl/pwm_deadtime_driver_if.sv
// Handshake bundle between the PID controller and the PWM output stage.
// Master drives enable and duty command; slave returns gate drives and status.
interface pwm_deadtime_driver_if;
  logic       en;
  logic [7:0] duty_in;
  logic       pwm_hi;
  logic       pwm_lo;
  logic [7:0] duty_active;
  logic       period_start;

  modport master (
    output en,
    output duty_in,
    input  pwm_hi,
    input  pwm_lo,
    input  duty_active,
    input  period_start
  );

  modport slave (
    input  en,
    input  duty_in,
    output pwm_hi,
    output pwm_lo,
    output duty_active,
    output period_start
  );
endinterface

// File: rtl/pwm_deadtime_driver.sv
// Complementary PWM gate driver with dead time and per-period slew limit.
// Duty command is latched only at period boundaries.
module pwm_deadtime_driver #(
  parameter int DIV  = 1,
  parameter int DEAD = 4,
  parameter int SLEW = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  pwm_deadtime_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON_HI,
    S_ON_LO,
    S_DEAD
  } state_t;

  localparam logic [7:0] PRE_MAX = 8'(DIV - 1);
  localparam logic [7:0] DC_LOAD = 8'((DEAD > 0) ? DEAD - 1 : 0);
  localparam logic [8:0] SLEW9   = 9'(SLEW);
  localparam logic [7:0] SLEW8   = 8'(SLEW);

  logic [7:0] r_pre;
  logic [7:0] r_cnt;
  logic [7:0] r_duty;
  logic [7:0] r_dc;
  logic       r_raw;
  logic       r_hi;
  logic       r_lo;
  state_t     r_state;

  logic       w_tick;
  logic       w_ps;
  logic       w_raw;
  logic [8:0] w_a;
  logic [8:0] w_d;
  logic [7:0] w_duty_nxt;

  assign w_tick = bus.en && (r_pre == PRE_MAX);
  assign w_ps   = rst_n && bus.en &&
                  (r_cnt == 8'd0) && (r_pre == 8'd0);
  assign w_raw  = (r_cnt < r_duty);
  assign w_a    = {1'b0, r_duty};
  assign w_d    = {1'b0, bus.duty_in};

  // Slew-limited next duty, evaluated in 9 bits so nothing wraps.
  always_comb begin
    w_duty_nxt = bus.duty_in;
    if (SLEW != 0) begin
      if (w_d > w_a + SLEW9)
        w_duty_nxt = r_duty + SLEW8;
      else if (w_d + SLEW9 < w_a)
        w_duty_nxt = r_duty - SLEW8;
    end
  end

  // Prescaler and 255-tick period counter; both cleared while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= 8'd0;
      r_cnt <= 8'd0;
    end else if (!bus.en) begin
      r_pre <= 8'd0;
      r_cnt <= 8'd0;
    end else if (w_tick) begin
      r_pre <= 8'd0;
      r_cnt <= (r_cnt == 8'd254) ? 8'd0 : r_cnt + 8'd1;
    end else begin
      r_pre <= r_pre + 8'd1;
    end
  end

  // Applied duty moves only at a period start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_duty <= 8'd0;
    else if (w_ps)
      r_duty <= w_duty_nxt;
  end

  // Gate FSM with registered outputs; dead window restarts if raw moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_dc    <= 8'd0;
      r_raw   <= 1'b0;
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
    end else begin
      r_raw <= w_raw;
      if (!bus.en) begin
        r_state <= S_IDLE;
        r_dc    <= 8'd0;
        r_hi    <= 1'b0;
        r_lo    <= 1'b0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (DEAD == 0) begin
              r_state <= w_raw ? S_ON_HI : S_ON_LO;
              r_hi    <= w_raw;
              r_lo    <= !w_raw;
            end else begin
              r_state <= S_DEAD;
              r_dc    <= DC_LOAD;
            end
          end
          S_ON_HI: begin
            if (!w_raw) begin
              r_hi <= 1'b0;
              if (DEAD == 0) begin
                r_state <= S_ON_LO;
                r_lo    <= 1'b1;
              end else begin
                r_state <= S_DEAD;
                r_dc    <= DC_LOAD;
              end
            end
          end
          S_ON_LO: begin
            if (w_raw) begin
              r_lo <= 1'b0;
              if (DEAD == 0) begin
                r_state <= S_ON_HI;
                r_hi    <= 1'b1;
              end else begin
                r_state <= S_DEAD;
                r_dc    <= DC_LOAD;
              end
            end
          end
          S_DEAD: begin
            if (w_raw != r_raw) begin
              r_dc <= DC_LOAD;
            end else if (r_dc == 8'd0) begin
              r_state <= w_raw ? S_ON_HI : S_ON_LO;
              r_hi    <= w_raw;
              r_lo    <= !w_raw;
            end else begin
              r_dc <= r_dc - 8'd1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_hi    <= 1'b0;
            r_lo    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pwm_hi       = r_hi;
  assign bus.pwm_lo       = r_lo;
  assign bus.duty_active  = r_duty;
  assign bus.period_start = w_ps;

endmodule

// File: tb/tb_pwm_deadtime_driver.sv
// Directed bench for pwm_deadtime_driver: three parameter sets share
// one clock and reset; each step carries hand-computed expectations.
module tb_pwm_deadtime_driver;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pwm_deadtime_driver_if b0 ();
  pwm_deadtime_driver_if b1 ();
  pwm_deadtime_driver_if b2 ();

  pwm_deadtime_driver #(.DIV(1), .DEAD(0), .SLEW(0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0.slave)
  );
  pwm_deadtime_driver #(.DIV(1), .DEAD(0), .SLEW(8)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );
  pwm_deadtime_driver #(.DIV(2), .DEAD(4), .SLEW(0)) u2 (
    .clk(clk), .rst_n(rst_n), .bus(b2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic bit ps_of(input int d);
    case (d)
      0:       return b0.period_start;
      1:       return b1.period_start;
      default: return b2.period_start;
    endcase
  endfunction

  task automatic wait_ps(input int d, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (ps_of(d)) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
    chk(tag, int'(ok), 1);
  endtask

  task automatic win0(input int n, output int hi, output int lo,
                      output int ps, output int ed, output int both);
    logic ph, pl;
    hi = 0; lo = 0; ps = 0; ed = 0; both = 0;
    ph = b0.pwm_hi;
    pl = b0.pwm_lo;
    for (int i = 0; i < n; i++) begin
      hi   += int'(b0.pwm_hi);
      lo   += int'(b0.pwm_lo);
      ps   += int'(b0.period_start);
      both += int'(b0.pwm_hi & b0.pwm_lo);
      if (b0.pwm_hi != ph || b0.pwm_lo != pl) ed++;
      ph = b0.pwm_hi;
      pl = b0.pwm_lo;
      step(1);
    end
  endtask

  initial begin
    int hi, lo, ps, ed, both;
    int gaps, bad_gaps, run;
    bit in_gap, gap_ok;
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    b0.en = 1'b0; b0.duty_in = 8'd0;
    b1.en = 1'b0; b1.duty_in = 8'd0;
    b2.en = 1'b0; b2.duty_in = 8'd0;
    step(3);

    chk("rst_hi", int'(b0.pwm_hi), 0);
    chk("rst_lo", int'(b0.pwm_lo), 0);
    chk("rst_duty", int'(b0.duty_active), 0);
    chk("rst_ps", int'(b0.period_start), 0);

    // 50% duty, DIV=1, DEAD=0
    rst_n = 1'b1;
    b0.en = 1'b1;
    b0.duty_in = 8'd128;
    #1;
    chk("ps_first", int'(b0.period_start), 1);
    step(255);
    chk("ps_255", int'(b0.period_start), 1);
    win0(255, hi, lo, ps, ed, both);
    chk("d50_hi", hi, 128);
    chk("d50_lo", lo, 127);
    chk("d50_ps", ps, 1);
    chk("d50_edges", ed, 2);
    chk("d50_both", both, 0);

    // asynchronous reset mid-period while pwm_hi is high
    step(10);
    chk("mid_hi", int'(b0.pwm_hi), 1);
    chk("mid_duty", int'(b0.duty_active), 128);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_hi", int'(b0.pwm_hi), 0);
    chk("arst_lo", int'(b0.pwm_lo), 0);
    chk("arst_duty", int'(b0.duty_active), 0);
    chk("arst_ps", int'(b0.period_start), 0);
    step(1);
    rst_n = 1'b1;
    b0.duty_in = 8'd0;
    #1;
    chk("ps_after_rst", int'(b0.period_start), 1);

    // duty 0 extreme
    step(300);
    win0(255, hi, lo, ps, ed, both);
    chk("d0_hi", hi, 0);
    chk("d0_lo", lo, 255);
    chk("d0_edges", ed, 0);

    // duty 255 extreme
    b0.duty_in = 8'd255;
    step(300);
    chk("d255_duty", int'(b0.duty_active), 255);
    win0(255, hi, lo, ps, ed, both);
    chk("d255_hi", hi, 255);
    chk("d255_lo", lo, 0);
    chk("d255_edges", ed, 0);

    // mid-period duty change waits for the next period start
    b0.duty_in = 8'd100;
    step(5);
    chk("hold_mid", int'(b0.duty_active), 255);
    wait_ps(0, "wait_ps_chg");
    chk("hold_at_ps", int'(b0.duty_active), 255);
    step(1);
    chk("upd_after_ps", int'(b0.duty_active), 100);

    // enable drop mid-period and restart
    step(20);
    chk("pre_drop_hi", int'(b0.pwm_hi), 1);
    b0.en = 1'b0;
    #1;
    chk("drop_ps", int'(b0.period_start), 0);
    step(1);
    chk("drop_hi", int'(b0.pwm_hi), 0);
    chk("drop_lo", int'(b0.pwm_lo), 0);
    chk("drop_duty", int'(b0.duty_active), 100);
    step(5);
    b0.duty_in = 8'd50;
    b0.en = 1'b1;
    #1;
    chk("restart_ps", int'(b0.period_start), 1);
    step(1);
    chk("restart_duty", int'(b0.duty_active), 50);
    step(254);
    chk("restart_next_ps", int'(b0.period_start), 1);
    b0.en = 1'b0;

    // slew limiting, SLEW=8
    b1.en = 1'b1;
    b1.duty_in = 8'd100;
    #1;
    for (int k = 1; k <= 13; k++) begin
      wait_ps(1, "wait_ps_up");
      step(1);
      chk($sformatf("slew_up_%0d", k), int'(b1.duty_active),
          (8 * k < 100) ? 8 * k : 100);
    end
    b1.duty_in = 8'd0;
    for (int k = 1; k <= 13; k++) begin
      wait_ps(1, "wait_ps_dn");
      step(1);
      chk($sformatf("slew_dn_%0d", k), int'(b1.duty_active),
          (k < 13) ? 100 - 8 * k : 0);
    end
    b1.en = 1'b0;

    // dead time, DIV=2, DEAD=4, duty 64
    b2.en = 1'b1;
    b2.duty_in = 8'd64;
    #1;
    step(600);
    wait_ps(2, "wait_ps_dead");
    chk("dead_duty", int'(b2.duty_active), 64);
    hi = 0; lo = 0; both = 0;
    gaps = 0; bad_gaps = 0; run = 0;
    in_gap = 1'b0; gap_ok = 1'b0;
    for (int i = 0; i < 5100; i++) begin
      hi   += int'(b2.pwm_hi);
      lo   += int'(b2.pwm_lo);
      both += int'(b2.pwm_hi & b2.pwm_lo);
      if (!b2.pwm_hi && !b2.pwm_lo) begin
        if (!in_gap) begin
          in_gap = 1'b1;
          gap_ok = (i > 0);
          run = 0;
        end
        run++;
      end else if (in_gap) begin
        in_gap = 1'b0;
        if (gap_ok) begin
          gaps++;
          if (run != 4) bad_gaps++;
        end
      end
      step(1);
    end
    chk("dead_hi", hi, 1240);
    chk("dead_lo", lo, 3780);
    chk("dead_both", both, 0);
    chk("dead_gaps", gaps, 20);
    chk("dead_gap_len", bad_gaps, 0);
    b2.en = 1'b0;
    step(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
